// File: rtl/dvi_timing_pkg.sv
// Shared constants and types for the DVI raster timing controller.
// 640x480@60 default timing, FSM state type, RGB pixel type and colour-bar table.
package dvi_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam bit DEF_SYNC_POL = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef logic [23:0] rgb24_t;

    // Left to right: white, yellow, cyan, green, magenta, red, blue, black.
    localparam rgb24_t COLOUR_BARS [0:7] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/dvi_axis_counter.sv
// One raster axis: wrap counter over active+porches+sync with active and sync-window decode.
// Used once per line (horizontal) and once per frame (vertical).
module dvi_axis_counter
    import dvi_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int W      = $clog2(ACTIVE + FP + SYNC + BP)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_step,
    output logic [W-1:0] o_cnt,
    output logic         o_last,
    output logic         o_active,
    output logic         o_sync
);

    localparam int TOT = h_total(ACTIVE, FP, SYNC, BP);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_step) begin
            r_cnt <= o_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt    = r_cnt;
    assign o_last   = (32'(r_cnt) == TOT - 1);
    assign o_active = (32'(r_cnt) < ACTIVE);
    assign o_sync   = (32'(r_cnt) >= ACTIVE + FP) && (32'(r_cnt) < ACTIVE + FP + SYNC);

endmodule

// File: rtl/dvi_video_timing_ctrl.sv
// DVI raster generator: hsync/vsync/de timing, pixel pull from upstream, registered TMDS-side outputs.
// Optional internal colour bars when built with DVI_TIMING_PATTERN_EN defined.
module dvi_video_timing_ctrl
    import dvi_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = DEF_SYNC_POL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        pix_valid,
    input  logic [23:0] pix_rgb,
    output logic        pix_rd,
    input  logic        test_mode,
    output logic [23:0] vid_rgb,
    output logic        vid_de,
    output logic        vid_hsync,
    output logic        vid_vsync,
    output logic        frame_start,
    output logic        running,
    output logic        underflow
);

    localparam int H_TOT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    state_t          r_state;
    logic            r_running;
    logic [HW-1:0]   w_hcnt;
    logic [VW-1:0]   w_vcnt;
    logic            w_h_last, w_h_active, w_h_sync;
    logic            w_v_last, w_v_active, w_v_sync;
    logic            w_run, w_active, w_frame_end, w_pix_rd;
    rgb24_t          w_src_rgb;
    rgb24_t          r_rgb;
    logic            r_de, r_hsync, r_vsync, r_frame_start, r_underflow;

    assign w_run = (r_state != IDLE);

    dvi_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(HW)
    ) u_hcnt (
        .clk(clk), .rst_n(rst_n), .i_clr(~w_run), .i_step(w_run),
        .o_cnt(w_hcnt), .o_last(w_h_last), .o_active(w_h_active), .o_sync(w_h_sync)
    );

    dvi_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(VW)
    ) u_vcnt (
        .clk(clk), .rst_n(rst_n), .i_clr(~w_run), .i_step(w_run & w_h_last),
        .o_cnt(w_vcnt), .o_last(w_v_last), .o_active(w_v_active), .o_sync(w_v_sync)
    );

    assign w_frame_end = w_h_last & w_v_last;
    assign w_active    = w_run & w_h_active & w_v_active;

`ifdef DVI_TIMING_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic [2:0] w_bar_idx;

    assign w_bar_idx = 3'(32'(w_hcnt) / BAR_W);
    // Colour bars are self-sourced, so upstream is never read and cannot underflow.
    assign w_pix_rd  = w_active & ~test_mode;
    assign w_src_rgb = test_mode ? COLOUR_BARS[w_bar_idx] : (pix_valid ? pix_rgb : '0);
`else
    logic w_unused_test_mode;

    assign w_unused_test_mode = test_mode;
    assign w_pix_rd  = w_active;
    assign w_src_rgb = pix_valid ? pix_rgb : '0;
`endif

    assign pix_rd = w_pix_rd;

    // Drain finishes only on the last pixel of a frame so the sink never sees a partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (enable) begin
                        r_state <= RUN;
                    end else if (w_frame_end) begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb         <= '0;
            r_de          <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_rgb         <= w_active ? w_src_rgb : '0;
            r_de          <= w_active;
            r_hsync       <= (w_run & w_h_sync) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= (w_run & w_v_sync) ? SYNC_POL : ~SYNC_POL;
            r_frame_start <= w_active & (w_hcnt == '0) & (w_vcnt == '0);
            r_underflow   <= r_underflow | (w_pix_rd & ~pix_valid);
        end
    end

    assign vid_rgb     = r_rgb;
    assign vid_de      = r_de;
    assign vid_hsync   = r_hsync;
    assign vid_vsync   = r_vsync;
    assign frame_start = r_frame_start;
    assign running     = r_running;
    assign underflow   = r_underflow;

endmodule
